// File: rtl/cam_xclk_ctrl.sv
// rtl/cam_xclk_ctrl.sv - sensor XCLK divider and power/reset sequencer; runtime divide under XCLK_DIV_RUNTIME_EN
module cam_xclk_ctrl #(
    parameter int DIV_HALF = 2,
    parameter int T_PWR    = 16,
    parameter int T_CLK    = 8,
    parameter int T_RST    = 32,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] div_half,
    output logic       xclk,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       ready,
    output logic       busy
);
    typedef enum logic [2:0] {S_OFF, S_PWR, S_CLK, S_RST, S_ON, S_STOP} state_t;

    state_t           r_state;
    logic             r_start;
    logic             r_stop;
    logic             r_clk_done;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_div;
    logic             r_xclk;
    logic             r_pwdn;
    logic             r_cam_rst_n;
    logic             r_ready;
    logic             r_busy;
    logic [7:0]       w_h;
    logic             w_div_tick;
    logic             w_rise;
    logic             w_run;
    logic             w_accept;

    assign w_accept = (r_state == S_OFF) && r_start && !r_stop;

`ifdef XCLK_DIV_RUNTIME_EN
    logic [7:0] r_h;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_h <= 8'(DIV_HALF);
        else if (w_accept)
            r_h <= div_half;
    end
    assign w_h = r_h;
`else
    localparam logic [7:0] LP_H = 8'(DIV_HALF);
    logic w_unused_div;
    assign w_unused_div = ^div_half;
    assign w_h = LP_H;
`endif

    assign w_div_tick = (r_div == w_h);
    assign w_rise     = w_div_tick && !r_xclk;
    // In STOP the divider only runs to finish a high phase, so xclk never gets a runt pulse.
    assign w_run      = (r_state == S_CLK) || (r_state == S_RST) || (r_state == S_ON) ||
                        ((r_state == S_STOP) && r_xclk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= 8'd0;
            r_xclk <= 1'b0;
        end else if (w_run) begin
            if (w_div_tick) begin
                r_div  <= 8'd0;
                r_xclk <= ~r_xclk;
            end else begin
                r_div <= r_div + 8'd1;
            end
        end else begin
            r_div  <= 8'd0;
            r_xclk <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_OFF;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_clk_done  <= 1'b0;
            r_cnt       <= '0;
            r_pwdn      <= 1'b1;
            r_cam_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_start <= start;
            r_stop  <= stop;
            case (r_state)
                S_OFF: begin
                    r_cnt      <= '0;
                    r_clk_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= S_PWR;
                        r_pwdn  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_PWR: begin
                    if (r_stop) begin
                        r_state <= S_STOP;
                    end else if (r_cnt == CNT_W'(T_PWR - 1)) begin
                        r_state <= S_CLK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CLK: begin
                    // The T_CLK-th rise is flagged, and reset is released one edge later.
                    if (r_stop) begin
                        r_state <= S_STOP;
                    end else if (r_clk_done) begin
                        r_state     <= S_RST;
                        r_cam_rst_n <= 1'b1;
                        r_cnt       <= '0;
                        r_clk_done  <= 1'b0;
                    end else if (w_rise) begin
                        if (r_cnt == CNT_W'(T_CLK - 1))
                            r_clk_done <= 1'b1;
                        else
                            r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RST: begin
                    if (r_stop) begin
                        r_state     <= S_STOP;
                        r_cam_rst_n <= 1'b0;
                    end else if (r_cnt == CNT_W'(T_RST - 1)) begin
                        r_state <= S_ON;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (r_stop) begin
                        r_state     <= S_STOP;
                        r_ready     <= 1'b0;
                        r_cam_rst_n <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (!r_xclk) begin
                        r_state <= S_OFF;
                        r_pwdn  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state     <= S_OFF;
                    r_pwdn      <= 1'b1;
                    r_cam_rst_n <= 1'b0;
                    r_ready     <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign xclk      = r_xclk;
    assign cam_pwdn  = r_pwdn;
    assign cam_rst_n = r_cam_rst_n;
    assign ready     = r_ready;
    assign busy      = r_busy;
endmodule

// File: tb/tb_cam_xclk_ctrl.sv
// tb/tb_cam_xclk_ctrl.sv - directed bench for cam_xclk_ctrl
module tb_cam_xclk_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] div_half = 8'd0;
    logic       xclk, cam_pwdn, cam_rst_n, ready, busy;

    int n_tests = 0;
    int n_fail  = 0;

    cam_xclk_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .div_half(div_half),
        .xclk(xclk), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({xclk, cam_pwdn, cam_rst_n, ready, busy});
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Returns edges between two successive xclk rises, or -1 on timeout.
    task automatic meas_period(output int p);
        logic prev;
        int   n;
        p    = -1;
        prev = xclk;
        n    = 0;
        while (!(!prev && xclk) && n < 200) begin
            prev = xclk;
            tick();
            n++;
        end
        if (n >= 200) return;
        n = 0;
        prev = xclk;
        do begin
            prev = xclk;
            tick();
            n++;
        end while (!(!prev && xclk) && n < 200);
        if (n < 200) p = n;
    endtask

    initial begin
        int   pwdn_fall, busy1, rise1, rise2, rise8, rstn_rise, ready_rise, nrise, highs, per, n;
        logic p_x, p_pwdn, p_rstn, p_ready;

        #1 rst_n = 1'b0;
        #1 chk_eq("reset_outs", outs(), 5'b01000);
        #10 rst_n = 1'b1;
        tick();
        tick();

        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (4) tick();
        chk_eq("start_stop_off", outs(), 5'b01000);

        // Default timeline: edge 0 samples start.
        pulse_start();
        chk_eq("edge0_pwdn", int'(cam_pwdn), 1);
        pwdn_fall = -1; busy1 = -1; rise1 = -1; rise2 = -1; rise8 = -1;
        rstn_rise = -1; ready_rise = -1; nrise = 0;
        p_x = xclk; p_pwdn = cam_pwdn; p_rstn = cam_rst_n; p_ready = ready;
        for (int e = 1; e <= 100; e++) begin
            if (e == 30) start = 1'b1;
            tick();
            start = 1'b0;
            if (e == 1) busy1 = int'(busy);
            if (p_pwdn && !cam_pwdn && pwdn_fall < 0) pwdn_fall = e;
            if (!p_x && xclk) begin
                nrise++;
                if (rise1 < 0) rise1 = e;
                else if (rise2 < 0) rise2 = e;
                if (nrise == 8) rise8 = e;
            end
            if (!p_rstn && cam_rst_n && rstn_rise < 0) rstn_rise = e;
            if (!p_ready && ready && ready_rise < 0) ready_rise = e;
            p_x = xclk; p_pwdn = cam_pwdn; p_rstn = cam_rst_n; p_ready = ready;
        end
        chk_eq("pwdn_fall_edge", pwdn_fall, 1);
        chk_eq("busy_edge1", busy1, 1);
        chk_eq("first_rise_edge", rise1, 20);
        chk_eq("xclk_period", rise2 - rise1, 6);
        chk_eq("rise8_edge", rise8, 62);
        chk_eq("rstn_rise_edge", rstn_rise, 63);
        chk_eq("ready_rise_edge", ready_rise, 95);

        // Stop in ON while xclk is high: R is the rise edge.
        n = 0;
        p_x = xclk;
        while (!(!p_x && xclk) && n < 20) begin
            p_x = xclk;
            tick();
            n++;
        end
        chk_eq("rise_wait_timeout", int'(n < 20), 1);
        pulse_stop();
        chk_eq("stop_r1_ready", int'(ready), 1);
        tick();
        chk_eq("stop_r2_ready", int'(ready), 0);
        chk_eq("stop_r2_rstn", int'(cam_rst_n), 0);
        chk_eq("stop_r2_xclk", int'(xclk), 1);
        tick();
        chk_eq("stop_r3_xclk", int'(xclk), 0);
        tick();
        chk_eq("stop_r4_outs", outs(), 5'b01000);
        highs = 0;
        repeat (10) begin
            tick();
            if (xclk) highs++;
        end
        chk_eq("stop_xclk_held_low", highs, 0);

        // Asynchronous reset while in RST.
        pulse_start();
        repeat (70) tick();
        chk_eq("in_rst_outs", int'({cam_pwdn, cam_rst_n, ready, busy}), 4'b0101);
        #2 rst_n = 1'b0;
        #1 chk_eq("async_reset_outs", outs(), 5'b01000);
        rst_n = 1'b1;
        repeat (20) tick();
        chk_eq("post_reset_idle", outs(), 5'b01000);
        pulse_start();
        tick();
        chk_eq("restart_busy_pwdn", int'({cam_pwdn, busy}), 2'b01);

`ifdef XCLK_DIV_RUNTIME_EN
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        div_half = 8'd0;
        pulse_start();
        meas_period(per);
        chk_eq("rt_period_h0", per, 2);
        n = 0;
        while (!ready && n < 300) begin
            tick();
            n++;
        end
        chk_eq("rt_ready_timeout", int'(ready), 1);
        div_half = 8'd5;
        meas_period(per);
        chk_eq("rt_period_unchanged", per, 2);
        pulse_stop();
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk_eq("rt_stop_idle", outs(), 5'b01000);
        pulse_start();
        meas_period(per);
        chk_eq("rt_period_h5", per, 12);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_xclk_ctrl.md
# cam_xclk_ctrl

Camera clock and power-up sequencer for the image-sensor interface. Generates the sensor's XCLK by dividing the system clock and drives the sensor's power-down and reset pins in the required order. Exposes a simple start/stop handshake to the capture front end. Sits between the system clock domain and the camera connector; `xclk` is a divided register output.

## Interface
- `DIV_HALF`, 2: `xclk` toggles every `DIV_HALF+1` clk cycles, giving an `xclk` period of `2*(DIV_HALF+1)` clk cycles. Used as the fixed ratio when runtime divide is compiled out.
- `T_PWR`, 16: clk cycles `cam_pwdn` is low before `xclk` starts (≥1).
- `T_CLK`, 8: `xclk` rising edges with `cam_rst_n` still low (≥1).
- `T_RST`, 32: clk cycles after `cam_rst_n` release before `ready` (≥1).
- `CNT_W`, 16: width of the shared delay counter; all T_* must be < 2^CNT_W.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; power the sensor up.
- `stop` in 1: single-cycle request; shut the sensor down.
- `div_half` in 8: runtime half-period minus one. Used only with `XCLK_DIV_RUNTIME_EN`.
- `xclk` out 1: camera clock.
- `cam_pwdn` out 1: sensor power-down, active high.
- `cam_rst_n` out 1: sensor reset, active low.
- `ready` out 1: sensor is clocked and out of reset.
- `busy` out 1: high in every state except OFF.

## Operation
- States are OFF, PWR, CLK, RST, ON and STOP. All outputs are registered.
- OFF:
  - `cam_pwdn`=1, `cam_rst_n`=0, `xclk`=0, `ready`=0, `busy`=0.
  - The divider counter is held at 0.
  - `start`=1 moves to PWR.
- PWR:
  - `cam_pwdn`=0.
  - Stays exactly `T_PWR` cycles, then moves to CLK.
- CLK:
  - The divider runs. The counter counts 0..H, where H is the latched half value. At count==H, `xclk` toggles and the counter resets to 0.
  - The state counter counts `xclk` rising toggles. On the `T_CLK`-th rise, moves to RST.
- RST:
  - `cam_rst_n`=1 and the divider keeps running.
  - After `T_RST` cycles, moves to ON.
- ON:
  - `ready`=1 and the divider keeps running.
- STOP:
  - `ready`=0 and `cam_rst_n`=0. The divider keeps running until `xclk` is low at a toggle boundary.
  - If `xclk` is already 0 on entry, the next cycle freezes the divider.
  - The divider is then frozen, the counter is cleared, and `cam_pwdn`=1. Moves to OFF.
  - `xclk` is therefore never truncated to a short high pulse.
- `stop` is honoured in PWR, CLK, RST and ON. In PWR, STOP has `xclk` already low and returns to OFF after one cycle.
- `start` is ignored outside OFF. `stop` is ignored in OFF and STOP.
- `start` and `stop` high in the same cycle: `stop` wins, so the block stays in OFF if already there.
- H is latched on the OFF→PWR transition. A value changed while running has no effect until the next start.
- H=0 gives `xclk` = clk/2.
- Counter arithmetic is unsigned and non-wrapping. Each state compares against its T_* parameter minus one.

## Timing
- Reset: asynchronous assertion forces the OFF output values immediately. Deassertion is used synchronously, and the block is in OFF on the first edge.
- `start` is sampled on edge N. `busy`=1 and `cam_pwdn`=0 take effect from edge N+1.
- The first `xclk` rise is `T_PWR+H+1` edges after N+1.
- `cam_rst_n` rises on the edge after the `T_CLK`-th `xclk` rise.
- `ready` rises `T_RST` edges after `cam_rst_n`.
- `stop` is sampled on edge M. `ready` and `cam_rst_n` drop at M+1. `cam_pwdn` rises at most H+2 edges after `xclk` is next low.
- Reset mid-sequence: immediate return to OFF values; no STOP sequence is run.

## Configuration
- `XCLK_DIV_RUNTIME_EN` defined: H is the `div_half` input, latched when `start` is accepted.
- `XCLK_DIV_RUNTIME_EN` undefined: `div_half` is unused and H = `DIV_HALF` as a constant. The divider compare folds to the constant.

## Test plan
- Defaults, `start` at edge 0:
  - `cam_pwdn` falls at edge 1.
  - The first `xclk` rise is at edge 20, with a period of 6 clk.
  - `cam_rst_n` rises at edge 63.
  - `ready` rises at edge 95.
- `stop` pulsed while in ON with `xclk` high:
  - `ready`=0 next edge.
  - `xclk` completes its high phase of 3 clk, then stays 0.
  - `cam_pwdn`=1 and `busy`=0 afterwards.
- `start` and `stop` together in OFF: no output changes. A `start` pulse during CLK is ignored and the timeline is unchanged.
- With `XCLK_DIV_RUNTIME_EN`:
  - `div_half`=0 at start gives an `xclk` period of 2 clk.
  - Changing `div_half` to 5 mid-ON leaves the period at 2.
  - Stop then restart gives a period of 12.
- `rst_n` asserted in RST: all outputs are at OFF values before the next clk edge. After release, the block waits for `start`.
